// File: rtl/biu_pkg.sv
// Shared definitions for the bus-interface scheduler: FSM state encoding
// and the default fetch pointer loaded at reset.
package biu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EU_LO,
        EU_HI,
        PF,
        HOLD
    } biu_state_t;

    localparam logic [19:0] RST_VEC_DEFAULT = 20'hFFFF0;

endpackage

// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch FIFO with wrap-around pointers, an occupancy
// count and a flush that empties it in one cycle.
module prefetch_queue #(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     valid,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(QDEPTH);

    logic [7:0]    mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pops on an empty queue are dropped; a push is only refused when full
    // and nothing leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/biu_arbiter.sv
// Schedules the byte-wide bus engine between DMA hold, EU data accesses and
// instruction prefetch; word accesses are split into low then high byte.
module biu_arbiter
    import biu_pkg::*;
#(
    parameter int            AW      = 20,
    parameter int            QDEPTH  = 4,
    parameter logic [AW-1:0] RST_VEC = AW'(RST_VEC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     eu_req,
    input  logic                     eu_we,
    input  logic                     eu_word,
    input  logic                     eu_iom,
    input  logic [AW-1:0]            eu_addr,
    input  logic [15:0]              eu_wdata,
    output logic [15:0]              eu_rdata,
    output logic                     eu_ack,
    input  logic                     pf_flush,
    input  logic [AW-1:0]            pf_addr,
    input  logic                     q_rd,
    output logic [7:0]               q_data,
    output logic                     q_valid,
    output logic [$clog2(QDEPTH):0]  q_count,
    input  logic                     hold,
    output logic                     hlda,
    output logic                     bc_start,
    output logic                     bc_we,
    output logic                     bc_iom,
    output logic [AW-1:0]            bc_addr,
    output logic [7:0]               bc_wdata,
    input  logic [7:0]               bc_rdata,
    input  logic                     bc_done
);

    localparam int            CW     = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

    biu_state_t    state, state_nx;
    logic          bc_start_nx, bc_we_nx, bc_iom_nx;
    logic [AW-1:0] bc_addr_nx;
    logic [7:0]    bc_wdata_nx;
    logic [15:0]   eu_rdata_nx;
    logic          eu_ack_nx, hlda_nx;
    logic [AW-1:0] fetch_ptr, fetch_ptr_nx;
    logic          pf_stale, pf_stale_nx;
    logic          q_push;

    prefetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (pf_flush),
        .push      (q_push),
        .push_data (bc_rdata),
        .pop       (q_rd),
        .head      (q_data),
        .valid     (q_valid),
        .count     (q_count)
    );

    // Next-state and next-output logic; every bus-facing output is a flop
    // loaded from these values. eu_req is ignored while eu_ack is high so a
    // requester that has not yet dropped its request is not serviced twice.
    always_comb begin
        state_nx    = state;
        bc_start_nx = 1'b0;
        bc_we_nx    = bc_we;
        bc_iom_nx   = bc_iom;
        bc_addr_nx  = bc_addr;
        bc_wdata_nx = bc_wdata;
        eu_rdata_nx = eu_rdata;
        eu_ack_nx   = 1'b0;
        hlda_nx     = 1'b0;
        pf_stale_nx = 1'b0;
        q_push      = 1'b0;

        case (state)
            IDLE: begin
                if (hold) begin
                    state_nx = HOLD;
                end else if (eu_req && !eu_ack) begin
                    state_nx    = EU_LO;
                    bc_start_nx = 1'b1;
                    bc_we_nx    = eu_we;
                    bc_iom_nx   = eu_iom;
                    bc_addr_nx  = eu_addr;
                    bc_wdata_nx = eu_wdata[7:0];
                end else if ((q_count < Q_FULL) && !pf_flush) begin
                    state_nx    = PF;
                    bc_start_nx = 1'b1;
                    bc_we_nx    = 1'b0;
                    bc_iom_nx   = 1'b0;
                    bc_addr_nx  = fetch_ptr;
                end
            end
            EU_LO: begin
                if (bc_done) begin
                    eu_rdata_nx[7:0] = bc_rdata;
                    if (eu_word) begin
                        state_nx    = EU_HI;
                        bc_start_nx = 1'b1;
                        bc_addr_nx  = eu_addr + 1'b1;
                        bc_wdata_nx = eu_wdata[15:8];
                    end else begin
                        eu_rdata_nx[15:8] = 8'h00;
                        eu_ack_nx         = 1'b1;
                        state_nx          = IDLE;
                    end
                end
            end
            EU_HI: begin
                if (bc_done) begin
                    eu_rdata_nx[15:8] = bc_rdata;
                    eu_ack_nx         = 1'b1;
                    state_nx          = IDLE;
                end
            end
            PF: begin
                // A flush at any point while the fetch is outstanding,
                // including the completion cycle, makes its byte stale.
                if (bc_done) begin
                    q_push   = !pf_stale && !pf_flush;
                    state_nx = IDLE;
                end else begin
                    pf_stale_nx = pf_stale || pf_flush;
                end
            end
            HOLD: begin
                hlda_nx = hold;
                if (!hold) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (pf_flush) begin
            fetch_ptr_nx = pf_addr;
        end else if (q_push) begin
            fetch_ptr_nx = fetch_ptr + 1'b1;
        end else begin
            fetch_ptr_nx = fetch_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bc_start  <= 1'b0;
            bc_we     <= 1'b0;
            bc_iom    <= 1'b0;
            bc_addr   <= '0;
            bc_wdata  <= '0;
            eu_rdata  <= '0;
            eu_ack    <= 1'b0;
            hlda      <= 1'b0;
            fetch_ptr <= RST_VEC;
            pf_stale  <= 1'b0;
        end else begin
            state     <= state_nx;
            bc_start  <= bc_start_nx;
            bc_we     <= bc_we_nx;
            bc_iom    <= bc_iom_nx;
            bc_addr   <= bc_addr_nx;
            bc_wdata  <= bc_wdata_nx;
            eu_rdata  <= eu_rdata_nx;
            eu_ack    <= eu_ack_nx;
            hlda      <= hlda_nx;
            fetch_ptr <= fetch_ptr_nx;
            pf_stale  <= pf_stale_nx;
        end
    end

endmodule
